// File: rtl/step_motor_driver_if.sv
// Control and status bundle for step_motor_driver: request/direction/enable in,
// coil drive and queue status out.
interface step_motor_driver_if;
  logic       enable;
  logic       step_req;
  logic       dir;
  logic [3:0] coil;
  logic       busy;
  logic [7:0] pending;
  logic       overflow;

  modport master (
    output enable, step_req, dir,
    input  coil, busy, pending, overflow
  );

  modport slave (
    input  enable, step_req, dir,
    output coil, busy, pending, overflow
  );
endinterface

// File: rtl/step_motor_driver.sv
// Four-phase stepper driver: queues STEPS_PER_PULSE steps per request, steps every
// STEP_DIV cycles, then holds the coils energized for HOLD_CYCLES before releasing.
module step_motor_driver #(
  parameter int unsigned STEP_DIV        = 50000,
  parameter int unsigned STEPS_PER_PULSE = 8,
  parameter int unsigned HOLD_CYCLES     = 100000
) (
  input logic               clk,
  input logic               rst_n,
  step_motor_driver_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] STEP = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  localparam logic [19:0] STEP_RELOAD = 20'(STEP_DIV - 1);
  localparam logic [19:0] HOLD_RELOAD = 20'(HOLD_CYCLES - 1);
  localparam logic [8:0]  SPP         = 9'(STEPS_PER_PULSE);

  logic [1:0]  state;
  logic [1:0]  phase_idx;
  logic [19:0] step_tmr;
  logic [19:0] hold_tmr;
  logic [7:0]  pending_q;
  logic        overflow_q;
  logic [3:0]  coil_q;

  logic        step_ev;
  logic [1:0]  next_idx;
  logic [8:0]  req_sum;
  logic [7:0]  pending_nx;
  logic        ovf_set;

  function automatic logic [3:0] phase_pattern(input logic [1:0] idx);
    logic [3:0] p;
    case (idx)
      2'd0:    p = 4'b0011;
      2'd1:    p = 4'b0110;
      2'd2:    p = 4'b1100;
      default: p = 4'b1001;
    endcase
    return p;
  endfunction

  // A step fires immediately from IDLE/HOLD, or on step-timer expiry in STEP.
  always_comb begin
    step_ev    = bus.enable && (pending_q != 8'd0) &&
                 ((state != STEP) || (step_tmr == '0));
    next_idx   = bus.dir ? (phase_idx - 2'd1) : (phase_idx + 2'd1);
    req_sum    = {1'b0, pending_q} + SPP - 9'(step_ev);
    ovf_set    = 1'b0;
    pending_nx = pending_q - 8'(step_ev);
    if (bus.step_req) begin
      ovf_set    = req_sum[8];
      pending_nx = req_sum[8] ? 8'hFF : req_sum[7:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      phase_idx  <= '0;
      step_tmr   <= '0;
      hold_tmr   <= '0;
      pending_q  <= '0;
      overflow_q <= 1'b0;
      coil_q     <= '0;
    end else if (!bus.enable) begin
      state      <= IDLE;
      step_tmr   <= '0;
      hold_tmr   <= '0;
      pending_q  <= '0;
      overflow_q <= 1'b0;
      coil_q     <= '0;
    end else begin
      pending_q <= pending_nx;
      if (ovf_set) overflow_q <= 1'b1;

      if (step_ev) begin
        phase_idx <= next_idx;
        coil_q    <= phase_pattern(next_idx);
        state     <= STEP;
        step_tmr  <= STEP_RELOAD;
      end else begin
        case (state)
          STEP: begin
            if (step_tmr == '0) begin
              state    <= HOLD;
              hold_tmr <= HOLD_RELOAD;
            end else begin
              step_tmr <= step_tmr - 20'd1;
            end
          end
          HOLD: begin
            if (hold_tmr == '0) begin
              state  <= IDLE;
              coil_q <= '0;
            end else begin
              hold_tmr <= hold_tmr - 20'd1;
            end
          end
          default: begin
            state  <= IDLE;
            coil_q <= '0;
          end
        endcase
      end
    end
  end

  assign bus.coil     = coil_q;
  assign bus.busy     = (state == STEP);
  assign bus.pending  = pending_q;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_step_motor_driver.sv
// Scoreboard bench for step_motor_driver: a timeline model predicts coil events and
// per-cycle status; a monitor pops and compares them against the DUT.
module tb_step_motor_driver;

  localparam int SD  = 4;
  localparam int SPP = 2;
  localparam int HC  = 6;
  localparam longint BIG = 64'd1000000000;
  localparam logic [3:0] PAT [4] = '{4'b0011, 4'b0110, 4'b1100, 4'b1001};

  typedef struct {
    int pend;
    bit busy;
    bit ovf;
  } st_t;

  logic clk = 1'b0;
  logic rst_n;
  logic rst2_n;

  step_motor_driver_if mif ();
  step_motor_driver_if sif ();

  step_motor_driver #(.STEP_DIV(SD), .STEPS_PER_PULSE(SPP), .HOLD_CYCLES(HC)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (mif)
  );

  step_motor_driver #(.STEP_DIV(SD), .STEPS_PER_PULSE(200), .HOLD_CYCLES(HC)) dut_sat (
    .clk  (clk),
    .rst_n(rst2_n),
    .bus  (sif)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit started = 1'b0;
  bit sat_done = 1'b0;

  logic [3:0] coil_q [$];
  st_t        status_q [$];

  // Reference model: step times, queue depth and coil-off deadline as plain arithmetic.
  longint     t;
  longint     last;
  int         pend;
  bit         ovf;
  bit         coil_on;
  int         ph;
  logic [3:0] exp_coil;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    last = -BIG; pend = 0; ovf = 0; coil_on = 0; ph = 0;
    if (exp_coil != 4'b0000) coil_q.push_back(4'b0000);
    exp_coil = 4'b0000;
  endtask

  task automatic model_edge(input bit en, input bit req, input bit d);
    bit ev, off;
    int s;
    logic [3:0] newc;
    st_t st;
    t++;
    if (!en) begin
      pend = 0; ovf = 0; coil_on = 0; last = -BIG;
    end else begin
      ev  = (pend > 0) && (t - last >= SD);
      off = !ev && coil_on && (pend == 0) && (t == last + SD + HC);
      if (ev) begin
        ph = d ? (ph + 3) % 4 : (ph + 1) % 4;
        last = t;
        coil_on = 1;
      end
      if (req) begin
        s = pend + SPP - int'(ev);
        if (s > 255) begin ovf = 1; s = 255; end
        pend = s;
      end else begin
        pend = pend - int'(ev);
      end
      if (off) coil_on = 0;
    end
    newc = coil_on ? PAT[ph] : 4'b0000;
    if (newc != exp_coil) coil_q.push_back(newc);
    exp_coil = newc;
    st.pend = pend;
    st.busy = coil_on && (t - last < SD);
    st.ovf  = ovf;
    status_q.push_back(st);
  endtask

  // Drive one cycle at the falling edge; optional async reset pulse inside the low phase.
  task automatic cycle(input bit en, input bit req, input bit d, input bit rstp);
    @(negedge clk);
    if (rstp) begin
      rst_n = 1'b0;
      mif.step_req = 1'b0;
      #1;
      chk("rst_coil", int'(mif.coil), 0);
      chk("rst_busy", int'(mif.busy), 0);
      chk("rst_pending", int'(mif.pending), 0);
      chk("rst_overflow", int'(mif.overflow), 0);
      #2;
      rst_n = 1'b1;
      model_reset();
    end
    mif.enable   = en;
    mif.step_req = req;
    mif.dir      = d;
    model_edge(en, req, d);
    started = 1'b1;
  endtask

  task automatic run(input bit en, input bit req, input bit d);
    cycle(en, req, d, 1'b0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops a coil event whenever coil moves, and one status record per edge.
  initial begin
    logic [3:0] prev = 4'b0000;
    st_t st;
    forever begin
      @(posedge clk);
      #1;
      if (started) begin
        if (mif.coil != prev) begin
          if (coil_q.size() == 0) begin
            chk("coil_unexpected", int'(mif.coil), int'(prev));
          end else begin
            chk("coil_event", int'(mif.coil), int'(coil_q.pop_front()));
          end
          prev = mif.coil;
        end
        if (status_q.size() == 0) begin
          chk("status_missing", 1, 0);
        end else begin
          st = status_q.pop_front();
          chk("pending", int'(mif.pending), st.pend);
          chk("busy", int'(mif.busy), int'(st.busy));
          chk("overflow", int'(mif.overflow), int'(st.ovf));
        end
      end
    end
  end

  // Saturation with STEPS_PER_PULSE=200 on a second instance.
  initial begin
    rst2_n = 1'b0;
    sif.enable = 1'b0; sif.step_req = 1'b0; sif.dir = 1'b0;
    repeat (2) @(negedge clk);
    rst2_n = 1'b1;
    @(negedge clk); sif.enable = 1'b1; sif.step_req = 1'b1;
    @(posedge clk); #1;
    chk("sat_first_pending", int'(sif.pending), 200);
    chk("sat_first_ovf", int'(sif.overflow), 0);
    @(negedge clk); sif.step_req = 1'b1;
    @(posedge clk); #1;
    chk("sat_pending", int'(sif.pending), 255);
    chk("sat_ovf", int'(sif.overflow), 1);
    @(negedge clk); sif.step_req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("sat_ovf_sticky", int'(sif.overflow), 1);
    end
    @(negedge clk); sif.enable = 1'b0;
    @(posedge clk); #1;
    chk("sat_ovf_clear", int'(sif.overflow), 0);
    chk("sat_pending_clear", int'(sif.pending), 0);
    sat_done = 1'b1;
  end

  initial begin
    bit d = 1'b0;
    bit en, req, rp;
    int dens;
    logic [3:0] ec;
    t = 0; exp_coil = 4'b0000;
    rst_n = 1'b0;
    mif.enable = 1'b0; mif.step_req = 1'b0; mif.dir = 1'b0;
    model_reset();
    #2;
    chk("init_coil", int'(mif.coil), 0);
    chk("init_busy", int'(mif.busy), 0);
    chk("init_pending", int'(mif.pending), 0);
    chk("init_overflow", int'(mif.overflow), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single forward request: edge k relative to the request edge.
    run(1, 1, 0);
    chk("single_pending_e0", int'(mif.pending), 2);
    for (int k = 1; k <= 16; k++) begin
      run(1, 0, 0);
      ec = (k >= 15) ? 4'b0000 : ((k < 5) ? 4'b0110 : 4'b1100);
      chk("single_coil", int'(mif.coil), int'(ec));
      chk("single_busy", int'(mif.busy), int'(k <= 8));
    end

    // Reverse from phase 0, then re-trigger 3 cycles into HOLD, then enable drop.
    cycle(1, 0, 1, 1);
    @(posedge clk); #1;
    run(1, 1, 1);
    for (int k = 1; k <= 11; k++) begin
      run(1, 0, 1);
      if (k == 1) chk("rev_coil_1", int'(mif.coil), 4'b1001);
      if (k == 5) chk("rev_coil_2", int'(mif.coil), 4'b1100);
      if (k >= 9) chk("hold_coil_on", int'(mif.coil != 4'b0000), 1);
    end
    run(1, 1, 1);
    chk("retrig_pending", int'(mif.pending), 2);
    chk("retrig_coil", int'(mif.coil), 4'b1100);
    run(1, 0, 1);
    chk("retrig_step_coil", int'(mif.coil), 4'b0110);
    chk("retrig_busy", int'(mif.busy), 1);
    chk("retrig_pending_dec", int'(mif.pending), 1);
    run(1, 1, 1);
    chk("abort_pending_pre", int'(mif.pending), 3);
    run(0, 0, 1);
    chk("abort_pending", int'(mif.pending), 0);
    chk("abort_coil", int'(mif.coil), 0);
    chk("abort_busy", int'(mif.busy), 0);

    // Reset pulse mid-HOLD.
    run(1, 1, 0);
    for (int k = 1; k <= 11; k++) run(1, 0, 0);
    chk("pre_rst_hold_coil", int'(mif.coil != 4'b0000), 1);
    cycle(1, 0, 0, 1);
    for (int k = 0; k < 4; k++) run(1, 0, 0);

    // Randomized segments of varying request density.
    for (int seg = 0; seg < 12; seg++) begin
      dens = (seg % 3 == 0) ? 40 : ((seg % 3 == 1) ? 6 : 2);
      for (int c = 0; c < 300; c++) begin
        en  = ($urandom_range(0, 999) != 0);
        req = ($urandom_range(0, dens - 1) == 0);
        if ($urandom_range(0, 19) == 0) d = ~d;
        rp  = ($urandom_range(0, 599) == 0);
        cycle(en, req, d, rp);
      end
    end
    for (int c = 0; c < 40; c++) cycle(1, 0, d, 0);

    @(posedge clk); #2;
    chk("coil_events_drained", coil_q.size(), 0);
    chk("status_drained", status_q.size(), 0);
    chk("sat_test_done", int'(sat_done), 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
